// File: rtl/median_ctrl_pkg.sv
// median_ctrl_pkg: shared state type, window constants and address clamp
package median_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_e;
    localparam int TAPS = 7;
    localparam int HALF_TAPS = 3;
    function automatic int clamp(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction
endpackage

// File: rtl/median_line_if.sv
// median_line_if: line memories, filter taps and start/status between control and sequencer
interface median_line_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    import median_ctrl_pkg::*;
    logic                           start;
    logic                           busy;
    logic                           done;
    logic                           rd_en;
    logic [ADDR_W-1:0]              rd_addr;
    logic [DATA_W-1:0]              rd_data;
    logic [TAPS-1:0][DATA_W-1:0]    mf_in;
    logic [DATA_W-1:0]              mf_out;
    logic                           wr_en;
    logic [ADDR_W-1:0]              wr_addr;
    logic [DATA_W-1:0]              wr_data;
    modport master(input start, rd_data, mf_out,
                   output busy, done, rd_en, rd_addr, mf_in, wr_en, wr_addr, wr_data);
    modport slave(output start, rd_data, mf_out,
                  input busy, done, rd_en, rd_addr, mf_in, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/mf_valid_delay.sv
// mf_valid_delay: DEPTH-cycle 1-bit shift register matching the filter pipeline
module mf_valid_delay #(
    parameter int DEPTH = 35
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr_q, sr_d;
    always_comb sr_d = DEPTH'({sr_q, din});
    always_ff @(posedge clk or negedge rst)
        if (!rst) sr_q <= '0;
        else      sr_q <= sr_d;
    assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/median_line_ctrl.sv
// median_line_ctrl: streams one line through the median filter with edge replication
module median_line_ctrl
    import median_ctrl_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10,
    parameter int LINE_LEN   = 640,
    parameter int MF_LATENCY = 35
) (
    input  logic         clk,
    input  logic         rst,
    median_line_if.master bus
);
    localparam int CNT_W = $clog2(LINE_LEN + TAPS);
    localparam logic [CNT_W-1:0]  K_LAST  = CNT_W'(LINE_LEN + TAPS - 2);
    localparam logic [CNT_W-1:0]  K_WIN   = CNT_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(LINE_LEN - 1);

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            k_q, k_d;
    logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;
    logic [TAPS-1:0][DATA_W-1:0] win_q, win_d;
    logic                        rd_vld_q, rd_vld_d;
    logic                        rd_ok_q, rd_ok_d;
    logic                        win_valid_q, win_valid_d;
    logic                        rd_en, busy, done, wr_en, last_wr;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            wr_addr_q   <= '0;
            win_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_ok_q     <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wr_addr_q   <= wr_addr_d;
            win_q       <= win_d;
            rd_vld_q    <= rd_vld_d;
            rd_ok_q     <= rd_ok_d;
            win_valid_q <= win_valid_d;
        end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.start ? READ : IDLE;
            READ:    state_d = k_q == K_LAST ? DRAIN : READ;
            DRAIN:   state_d = last_wr ? FIN : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en = state_q == READ;
        busy  = state_q == READ || state_q == DRAIN;
        done  = state_q == FIN;
    end

    // read k lands on mf_in6 two cycles later; only k >= 6 completes a fresh window
    always_comb begin
        k_d         = rd_en ? k_q + 1'b1 : '0;
        rd_vld_d    = rd_en;
        rd_ok_d     = rd_en && k_q >= K_WIN;
        win_valid_d = rd_ok_q;
        win_d       = rd_vld_q ? {bus.rd_data, win_q[TAPS-1:1]} : win_q;
        last_wr     = wr_en && wr_addr_q == A_LAST;
        wr_addr_d   = (state_q == IDLE && bus.start) ? '0 : wr_en ? wr_addr_q + 1'b1 : wr_addr_q;
    end

    mf_valid_delay #(.DEPTH(MF_LATENCY)) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (win_valid_q),
        .dout (wr_en)
    );

    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = ADDR_W'(clamp(int'(k_q) - HALF_TAPS, 0, LINE_LEN - 1));
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.mf_in   = win_q;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = bus.mf_out;
endmodule

// File: tb/tb_median_line_ctrl.sv
// tb_median_line_ctrl: directed checks of line sequencing, edge replication and latency alignment
module tb_median_line_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   nw, nd, nr, fw, fd;
    logic [7:0] ram8 [8];
    logic [7:0] res8 [8];
    logic [7:0] exp8 [8];
    logic [34:0][7:0] p8, p1;
    logic [6:0][7:0] w_first, w_last;

    always #5 clk = ~clk;

    median_line_if #(.DATA_W(8), .ADDR_W(10)) bus8 ();
    median_line_if #(.DATA_W(8), .ADDR_W(10)) bus1 ();

    median_line_ctrl #(.DATA_W(8), .ADDR_W(10), .LINE_LEN(8), .MF_LATENCY(35)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8));
    median_line_ctrl #(.DATA_W(8), .ADDR_W(10), .LINE_LEN(1), .MF_LATENCY(35)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    function automatic logic [7:0] med7(input logic [6:0][7:0] w);
        int a [7];
        int t;
        for (int i = 0; i < 7; i++) a[i] = int'(w[i]);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return 8'(a[3]);
    endfunction

    always @(posedge clk) begin
        bus8.rd_data <= bus8.rd_en ? ram8[bus8.rd_addr[2:0]] : bus8.rd_data;
        bus1.rd_data <= bus1.rd_en ? (bus1.rd_addr == 10'd0 ? 8'd77 : 8'd0) : bus1.rd_data;
        p8 <= {p8[33:0], med7(bus8.mf_in)};
        p1 <= {p1[33:0], med7(bus1.mf_in)};
    end
    assign bus8.mf_out = p8[34];
    assign bus1.mf_out = p1[34];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_rd(input int k);
        return k < 3 ? 0 : (k - 3 > 7 ? 7 : k - 3);
    endfunction

    task automatic run8(input int st1, input int st2, input int rst_at);
        for (int i = 0; i < 8; i++) res8[i] = 8'd0;
        bus8.start = 1'b1;
        tick;
        bus8.start = 1'b0;
        nw = 0; nd = 0; nr = 0; fw = -1; fd = -1;
        for (int n = 0; n < 70; n++) begin
            if (bus8.rd_en) begin
                nr++;
                chk("rd_addr", 64'(bus8.rd_addr), 64'(exp_rd(n)));
            end
            if (bus8.wr_en) begin
                if (fw < 0) fw = n;
                chk("wr_addr", 64'(bus8.wr_addr), 64'(nw));
                res8[bus8.wr_addr[2:0]] = bus8.wr_data;
                nw++;
            end
            if (bus8.done) begin
                if (fd < 0) fd = n;
                nd++;
            end
            if (n == 8)  chk("win_first", 64'(bus8.mf_in), 64'(w_first));
            if (n == 15) chk("win_last", 64'(bus8.mf_in), 64'(w_last));
            bus8.start = (n == st1 || n == st2);
            rst = (n != rst_at);
            tick;
        end
        bus8.start = 1'b0;
        rst = 1'b1;
    endtask

    task automatic check_line(input string tag);
        chk({tag, "_reads"}, 64'(nr), 64'd14);
        chk({tag, "_writes"}, 64'(nw), 64'd8);
        chk({tag, "_first_wr"}, 64'(fw), 64'd43);
        chk({tag, "_done_cyc"}, 64'(fd), 64'd51);
        chk({tag, "_done_cnt"}, 64'(nd), 64'd1);
        for (int i = 0; i < 8; i++) chk({tag, "_res"}, 64'(res8[i]), 64'(exp8[i]));
    endtask

    initial begin
        ram8 = '{8'd10, 8'd200, 8'd20, 8'd30, 8'd255, 8'd40, 8'd50, 8'd60};
        exp8 = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd50, 8'd60, 8'd60};
        w_first = {8'd30, 8'd20, 8'd200, 8'd10, 8'd10, 8'd10, 8'd10};
        w_last  = {8'd60, 8'd60, 8'd60, 8'd60, 8'd50, 8'd40, 8'd255};
        bus8.start = 1'b0;
        bus1.start = 1'b0;
        rst = 1'b0;
        tick;
        tick;
        chk("rst_rd_addr", 64'(bus8.rd_addr), 64'd0);
        chk("rst_wr_addr", 64'(bus8.wr_addr), 64'd0);
        rst = 1'b1;
        for (int n = 0; n < 100; n++) begin
            chk("idle8", 64'({bus8.busy, bus8.done, bus8.rd_en, bus8.wr_en, |bus8.mf_in}), 64'd0);
            chk("idle1", 64'({bus1.busy, bus1.done, bus1.rd_en, bus1.wr_en, |bus1.mf_in}), 64'd0);
            tick;
        end

        run8(-1, -1, -1);
        check_line("basic");

        run8(5, 30, -1);
        check_line("busy_start");

        run8(51, -1, -1);
        check_line("fin_start");

        run8(-1, -1, 20);
        chk("abort_writes", 64'(nw), 64'd0);
        chk("abort_done", 64'(nd), 64'd0);
        chk("abort_busy", 64'(bus8.busy), 64'd0);
        run8(-1, -1, -1);
        check_line("after_abort");

        bus1.start = 1'b1;
        tick;
        bus1.start = 1'b0;
        nw = 0; nd = 0; nr = 0; fw = -1; fd = -1;
        for (int n = 0; n < 60; n++) begin
            if (bus1.rd_en) begin
                nr++;
                chk("len1_rd_addr", 64'(bus1.rd_addr), 64'd0);
            end
            if (bus1.wr_en) begin
                if (fw < 0) fw = n;
                nw++;
                chk("len1_wr_addr", 64'(bus1.wr_addr), 64'd0);
                chk("len1_wr_data", 64'(bus1.wr_data), 64'd77);
            end
            if (bus1.done) begin
                if (fd < 0) fd = n;
                nd++;
            end
            tick;
        end
        chk("len1_reads", 64'(nr), 64'd7);
        chk("len1_writes", 64'(nw), 64'd1);
        chk("len1_first_wr", 64'(fw), 64'd43);
        chk("len1_done_cyc", 64'(fd), 64'd44);
        chk("len1_done_cnt", 64'(nd), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/median_line_ctrl.md
Name: median_line_ctrl

Overview:
Sequencer that runs the existing 7-input, 8-bit medianfilter datapath over one line of pixels held in a synchronous pixel RAM, and writes the filtered line to a result RAM.
- Generates read addresses and builds a sliding 7-tap window, with edge pixels replicated at both ends of the line.
- Drives the filter inputs every cycle.
- Tracks the filter's fixed pipeline latency so each result is written to the correct address.
- Sits between the line memories and the free-running medianfilter instance; it is started and monitored by the top-level control.

Parameters:
- DATA_W, 8, pixel width; must match the filter.
- ADDR_W, 10, address width of both RAMs.
- LINE_LEN, 640, pixels per line; valid range 1..2**ADDR_W.
- MF_LATENCY, 35, clocks from filter input change to matching out value.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to filter one line; honoured only in IDLE.
- busy  out  1  high from the first read cycle through the last write cycle.
- done  out  1  one-cycle pulse the cycle after the last write.
- rd_en  out  1  pixel RAM read strobe.
- rd_addr  out  ADDR_W  pixel RAM address.
- rd_data  in  DATA_W  pixel RAM data; valid 1 cycle after rd_en.
- mf_in0..mf_in6  out  DATA_W each  filter inputs; mf_in0 is the leftmost (oldest) pixel, mf_in6 the rightmost (newest).
- mf_out  in  DATA_W  filter result.
- wr_en  out  1  result RAM write strobe.
- wr_addr  out  ADDR_W  result RAM address.
- wr_data  out  DATA_W  result RAM data; equals mf_out.

Behaviour:
Reset (rst=0, asynchronous):
- State IDLE.
- busy, done, rd_en and wr_en are 0.
- rd_addr and wr_addr are 0.
- Window registers and mf_in0..6 are 0.
- Valid delay line is cleared.
- A reset mid-line aborts the line: no further writes occur and done is not pulsed.

States: IDLE -> READ -> DRAIN -> FIN -> IDLE.
- IDLE: start=1 moves to READ; cycle c0 is the first READ cycle.
- READ: lasts LINE_LEN+6 cycles, k = 0..LINE_LEN+5.
  - rd_en=1 and rd_addr = clamp(k-3, 0, LINE_LEN-1).
  - After the last read, go to DRAIN.
- DRAIN: wait until the delayed valid for the last window has been written, then go to FIN.
- FIN: done=1 for one cycle, busy=0, then IDLE.

Window:
- On each cycle where rd_data is valid (the cycle after a read), shift it in: mf_in0 <= mf_in1 ... mf_in6 <= rd_data.
- Data from read k is therefore visible on mf_in6 in cycle c0+k+2.
- win_valid is high in cycle c0+k+2 for k >= 6. The window then holds clamped addresses k-9..k-3, centred on pixel index k-6.
- Example: the first valid window holds addresses 0,0,0,0,1,2,3.

Latency matching:
- win_valid feeds an MF_LATENCY-deep shift register.
- Its output is wr_en.
- wr_addr starts at 0 and increments after each write.
- wr_data = mf_out, taken combinationally in the same cycle.
- First write occurs in cycle c0+8+MF_LATENCY. Last write (index LINE_LEN-1) occurs in cycle c0+LINE_LEN+7+MF_LATENCY.
- Exactly LINE_LEN writes per line, with consecutive addresses and no gaps.

Other rules:
- start while busy is ignored; start in the FIN cycle is also ignored.
- LINE_LEN=1 is legal: all 7 taps equal pixel 0, and one write occurs.
- Counters must be sized for LINE_LEN+6 without overflow.
- mf_in holds its last value outside READ; the filter output is ignored then because wr_en=0.

Decomposition:
- Package median_ctrl_pkg holds:
  - the state enum (IDLE, READ, DRAIN, FIN);
  - the constants TAPS=7 and HALF_TAPS=3;
  - the clamp helper function.
- Sub-module mf_valid_delay (parameter DEPTH) implements the 1-bit latency-matching shift register with asynchronous active-low clear.
- The window and FSM stay in median_line_ctrl.

Test Plan:
- Reset then idle: rst low for 2 cycles, then high with no start -> busy=done=rd_en=wr_en=0 and all mf_in=0 for 100 cycles.
- Basic line: LINE_LEN=8, RAM = 10,200,20,30,255,40,50,60; pulse start; bench uses a reference filter model with latency 35 ->
  - result RAM = 10,20,30,40,50,50,60,60;
  - first wr_en at c0+43, done at c0+51, 8 writes total.
- Edge replicate: in the basic line test, check mf_in0..6 at c0+8 -> 10,10,10,10,200,20,30; and at c0+15 (last valid window) -> 255,40,50,60,60,60,60.
- Start while busy: pulse start again at c0+5 and at c0+30 -> exactly 8 writes and a single done pulse; rd_addr sequence unchanged.
- Reset mid-line: assert rst at c0+20 for 1 cycle -> no wr_en afterwards and no done; a following start produces a complete, correct line.
- LINE_LEN=1 with pixel 77 -> 7 reads all at address 0, one write of 77 to address 0 at c0+43, done at c0+44.
